// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide, start/done handshake.
// Optional macro MDU_EARLY_TERM_EN: multiply stops once the remaining multiplier bits are all zero.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               neg_res;
    logic               neg_rem;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   dsor;
    logic [WIDTH:0]     rem;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH+1:0]   trial;
    logic               q_bit;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   rem_low;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               mul_last;
    logic               div_last;

    // Operand magnitudes; abs of MIN wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign mag_a = (op_sign && a[WIDTH-1]) ? -a : a;
    assign mag_b = (op_sign && b[WIDTH-1]) ? -b : b;

    // Multiply: sreg holds the remaining multiplier bits, mcand the multiplicand shifted into place.
    assign prod_next = prod + (sreg[0] ? mcand : '0);
    assign prod_fix  = neg_res ? -prod_next : prod_next;

    // Divide: sreg shifts the dividend out at the top while quotient bits enter at the bottom.
    assign trial    = {rem, sreg[WIDTH-1]} - {2'b00, dsor};
    assign q_bit    = ~trial[WIDTH+1];
    assign rem_next = q_bit ? trial[WIDTH:0] : {rem[WIDTH-1:0], sreg[WIDTH-1]};
    assign quo_next = {sreg[WIDTH-2:0], q_bit};
    assign rem_low  = rem_next[WIDTH-1:0];
    assign quo_fix  = neg_res ? -quo_next : quo_next;
    assign rem_fix  = neg_rem ? -rem_low : rem_low;

`ifdef MDU_EARLY_TERM_EN
    assign mul_last = (cnt == CNT_LAST) || (sreg[WIDTH-1:1] == '0);
`else
    assign mul_last = (cnt == CNT_LAST);
`endif
    assign div_last = (cnt == CNT_LAST);

    // The final iteration feeds sign correction directly, so hi/lo/done are valid throughout FIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            prod     <= '0;
            mcand    <= '0;
            sreg     <= '0;
            dsor     <= '0;
            rem      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        div_zero <= 1'b0;
                        neg_res  <= op_sign && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem  <= op_sign && a[WIDTH-1];
                        if (op_div) begin
                            if (b == '0) begin
                                state    <= FIN;
                                done     <= 1'b1;
                                div_zero <= 1'b1;
                            end else begin
                                state <= DIV;
                                busy  <= 1'b1;
                                sreg  <= mag_a;
                                dsor  <= mag_b;
                                rem   <= '0;
                            end
                        end else begin
                            state <= MUL;
                            busy  <= 1'b1;
                            prod  <= '0;
                            mcand <= {{WIDTH{1'b0}}, mag_a};
                            sreg  <= mag_b;
                        end
                    end
                end
                MUL: begin
                    prod  <= prod_next;
                    mcand <= mcand << 1;
                    sreg  <= sreg >> 1;
                    cnt   <= cnt + 1'b1;
                    if (mul_last) begin
                        {hi, lo} <= prod_fix;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= FIN;
                    end
                end
                DIV: begin
                    rem  <= rem_next;
                    sreg <= quo_next;
                    cnt  <= cnt + 1'b1;
                    if (div_last) begin
                        lo    <= quo_fix;
                        hi    <= rem_fix;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
